// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level flags, occupancy count and sticky
// overflow/underflow errors; a clock-enable lets it run from a divider tick.
module sync_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 256,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow,
    input  logic          err_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr_acc;
    logic          rd_acc;
    logic          ov_set;
    logic          un_set;
    logic [CW-1:0] count_nxt;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_acc    = ce & rd_en & ~empty;
        wr_acc    = ce & wr_en & (~full | rd_acc);
        ov_set    = ce & wr_en & ~wr_acc;
        un_set    = ce & rd_en & ~rd_acc;
        count_nxt = count;
        if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // NOTE: storage has no reset; only pointers/count are cleared, which already
    // makes old contents unreachable and keeps the array mappable to RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) begin
                wptr <= ptr_inc(wptr);
            end
            if (rd_acc) begin
                rd_data <= mem[rptr];
                rptr    <= ptr_inc(rptr);
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

    // Error flags: a new error in the same cycle as err_clr takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ov_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (un_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (DEPTH=8, AF_LEVEL=6, AE_LEVEL=2) using a
// reference occupancy model and a data scoreboard queue.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb[$];
    logic [CW-1:0] m_count;
    logic          m_ov;
    logic          m_un;
    logic [DW-1:0] last_rd;

    sync_fifo #(
        .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: the model decides acceptance, the scoreboard
    // supplies the expected popped word, and outputs are sampled 1ns after the edge.
    task automatic step(input logic c, input logic w, input logic [DW-1:0] wd,
                        input logic r, input logic e);
        logic          ra;
        logic          wa;
        logic [DW-1:0] exp_d;
        ra    = c & r & (m_count != '0);
        wa    = c & w & ((m_count != CW'(DEPTH)) | ra);
        exp_d = '0;
        if (ra) exp_d = sb.pop_front();
        if (wa) sb.push_back(wd);
        if (wa && !ra) m_count = m_count + 1'b1;
        else if (ra && !wa) m_count = m_count - 1'b1;
        if (c & w & ~wa) m_ov = 1'b1;
        else if (e) m_ov = 1'b0;
        if (c & r & ~ra) m_un = 1'b1;
        else if (e) m_un = 1'b0;
        ce = c; wr_en = w; wr_data = wd; rd_en = r; err_clr = e;
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_valid !== ra) begin
            n_fail++;
            $display("FAIL rd_valid: got %b expected %b", rd_valid, ra);
        end
        if (ra) begin
            n_checks++;
            if (rd_data !== exp_d) begin
                n_fail++;
                $display("FAIL rd_data: got %h expected %h", rd_data, exp_d);
            end
        end
        n_checks++;
        if (count !== m_count) begin
            n_fail++;
            $display("FAIL count: got %0d expected %0d", count, m_count);
        end
        n_checks++;
        if (overflow !== m_ov || underflow !== m_un) begin
            n_fail++;
            $display("FAIL err_flags: got ov=%b un=%b expected ov=%b un=%b",
                     overflow, underflow, m_ov, m_un);
        end
        last_rd = rd_data;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; ce = 1'b1;
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = '0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
            almost_empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d e=%b f=%b af=%b ae=%b v=%b d=%h ov=%b un=%b expected 0,1,0,0,1,0,00,0,0",
                     tag, count, empty, full, almost_full, almost_empty, rd_valid,
                     rd_data, overflow, underflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; ce = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0; err_clr = 1'b0;
        #12;
        check_reset_values("reset_initial");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        // Traffic: overfill, then pop one so rd_data and overflow are non-zero.
        for (int i = 0; i < 9; i++) step(1, 1, DW'(8'hC0 + i), 0, 0);
        step(1, 0, '0, 1, 0);
        step(1, 1, 8'h77, 0, 0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("reset_async");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(1, 0, '0, 0, 0);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) step(1, 1, DW'(i), 0, 0);
        n_checks++;
        if (full !== 1'b1 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b empty=%b expected 1 0", full, empty);
        end
        step(1, 1, 8'h09, 0, 0);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_overflow: got %b expected 1", overflow);
        end
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 0);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || last_rd !== 8'h08) begin
            n_fail++;
            $display("FAIL drain_empty: got empty=%b full=%b last=%h expected 1 0 08",
                     empty, full, last_rd);
        end
        step(1, 0, '0, 0, 1);
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) step(1, 1, DW'(8'h20 + r * 16 + i), 0, 0);
            for (int i = 0; i < 5; i++) step(1, 0, '0, 1, 0);
        end
        n_checks++;
        if (empty !== 1'b1 || last_rd !== 8'h54) begin
            n_fail++;
            $display("FAIL wrap_end: got empty=%b last=%h expected 1 54", empty, last_rd);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step(1, 1, DW'(8'h10 + i), 0, 0);
        step(1, 1, 8'hAA, 1, 0);
        n_checks++;
        if (full !== 1'b1 || last_rd !== 8'h10) begin
            n_fail++;
            $display("FAIL simul_full: got full=%b data=%h expected 1 10", full, last_rd);
        end
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 0);
        n_checks++;
        if (last_rd !== 8'hAA || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_last: got data=%h empty=%b expected AA 1", last_rd, empty);
        end
        step(1, 1, 8'h55, 1, 0);
        n_checks++;
        if (underflow !== 1'b1 || count !== CW'(1) || rd_valid !== 1'b0 || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_empty: got un=%b cnt=%0d v=%b empty=%b expected 1 1 0 0",
                     underflow, count, rd_valid, empty);
        end
        step(1, 0, '0, 1, 1);
    endtask

    task automatic test_thresholds();
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, DW'(8'h60 + k), 0, 0);
            n_checks++;
            if (almost_full !== (k >= 6) || almost_empty !== (k <= 2)) begin
                n_fail++;
                $display("FAIL thr_wr%0d: got af=%b ae=%b expected %b %b",
                         k, almost_full, almost_empty, k >= 6, k <= 2);
            end
        end
        for (int k = 7; k >= 0; k--) begin
            step(1, 0, '0, 1, 0);
            n_checks++;
            if (almost_full !== (k >= 6) || almost_empty !== (k <= 2)) begin
                n_fail++;
                $display("FAIL thr_rd%0d: got af=%b ae=%b expected %b %b",
                         k, almost_full, almost_empty, k >= 6, k <= 2);
            end
        end
    endtask

    task automatic test_ce_gating();
        for (int i = 0; i < 16; i++) step((i % 4) == 3, 1, DW'(8'h80 + i), 0, 0);
        n_checks++;
        if (count !== CW'(4)) begin
            n_fail++;
            $display("FAIL ce_writes: got %0d expected 4", count);
        end
        for (int i = 0; i < 5; i++) step(1, 1, DW'(8'h90 + i), 0, 0);
        n_checks++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_ovf: got ov=%b full=%b expected 1 1", overflow, full);
        end
        step(0, 0, '0, 0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_errclr: got %b expected 0", overflow);
        end
        step(0, 1, 8'hEE, 1, 0);
        n_checks++;
        if (overflow !== 1'b0 || rd_valid !== 1'b0 || count !== CW'(8)) begin
            n_fail++;
            $display("FAIL ce_hold: got ov=%b v=%b cnt=%0d expected 0 0 8",
                     overflow, rd_valid, count);
        end
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 0);
        n_checks++;
        if (last_rd !== 8'h93 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_drain: got data=%h empty=%b expected 93 1", last_rd, empty);
        end
    endtask

    initial begin
        model_reset();
        last_rd = '0;
        test_reset();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_thresholds();
        test_ce_gating();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
